icache_tag_ctl: RTL and testbench

//  Sequencer/arbiter for the 4-way I-cache tag array (7b index, 33b tag/way).

---
 rtl/icache_tag_ctl_if.sv | 35 +++
 rtl/icache_tag_ctl.sv | 92 +++++++++
 tb/tb_icache_tag_ctl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_tag_ctl_if.sv
// Request/grant and tag-array strobe bundle between the IFU fetch/fill logic and icache_tag_ctl.
// master = requester side, slave = the tag controller.
interface icache_tag_ctl_if #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 33
);
  logic             fetch_req;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_gnt;
  logic             fill_req;
  logic [IDX_W-1:0] fill_idx;
  logic [3:0]       fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_gnt;
  logic             inv_start;
  logic             inv_busy;
  logic [IDX_W-1:0] index_x;
  logic             rdreq_x;
  logic             wrreq_x;
  logic [3:0]       wrway_x;
  logic [TAG_W-1:0] wrtag_y;
  logic             rdvld_y;

  modport master (
    output fetch_req, fetch_idx, fill_req, fill_idx, fill_way, fill_tag, inv_start,
    input  fetch_gnt, fill_gnt, inv_busy, index_x, rdreq_x, wrreq_x, wrway_x,
           wrtag_y, rdvld_y
  );

  modport slave (
    input  fetch_req, fetch_idx, fill_req, fill_idx, fill_way, fill_tag, inv_start,
    output fetch_gnt, fill_gnt, inv_busy, index_x, rdreq_x, wrreq_x, wrway_x,
           wrtag_y, rdvld_y
  );
endinterface

// File: rtl/icache_tag_ctl.sv
// I-cache tag-array port sequencer: invalidate sweep after reset or on request,
// then fetch-read / fill-write arbitration with a bounded fetch starvation window.
//
//  state | meaning
//  SWEEP | write all four ways of every set with a zero tag, one set per cycle
//  RUN   | arbitrate fetch lookups and fill writes, one access per cycle
module icache_tag_ctl #(
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 33,
  parameter int STARVE = 3
) (
  input logic             rclk,
  input logic             reset_l,
  icache_tag_ctl_if.slave bus
);
  localparam int SC_W = $clog2(STARVE + 1);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic [SC_W-1:0]  starve_cnt;
  logic             fill_win;

  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) state <= SWEEP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SWEEP:   if (sweep_cnt == '1) state_nxt = RUN;
      RUN:     if (bus.inv_start)   state_nxt = SWEEP;
      default: state_nxt = SWEEP;
    endcase
  end

  // Fill wins unless the waiting fetch has already been passed over STARVE times.
  assign fill_win = bus.fill_req & (~bus.fetch_req | (starve_cnt < SC_W'(STARVE)));

  always_comb begin
    bus.fetch_gnt = 1'b0;
    bus.fill_gnt  = 1'b0;
    bus.inv_busy  = 1'b0;
    bus.index_x   = bus.fetch_idx;
    bus.rdreq_x   = 1'b0;
    bus.wrreq_x   = 1'b0;
    bus.wrway_x   = 4'b0000;
    case (state)
      SWEEP: begin
        bus.inv_busy = 1'b1;
        bus.index_x  = sweep_cnt;
        bus.wrreq_x  = 1'b1;
        bus.wrway_x  = 4'b1111;
      end
      RUN: begin
        if (fill_win) begin
          bus.fill_gnt = 1'b1;
          bus.index_x  = bus.fill_idx;
          bus.wrreq_x  = 1'b1;
          bus.wrway_x  = bus.fill_way;
        end else if (bus.fetch_req) begin
          bus.fetch_gnt = 1'b1;
          bus.rdreq_x   = 1'b1;
        end
      end
      default: bus.inv_busy = 1'b1;
    endcase
  end

  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      sweep_cnt   <= '0;
      starve_cnt  <= '0;
      bus.wrtag_y <= '0;
      bus.rdvld_y <= 1'b0;
    end else begin
      bus.rdvld_y <= bus.rdreq_x;
      if (bus.wrreq_x) bus.wrtag_y <= (state == SWEEP) ? '0 : bus.fill_tag;

      if (state == SWEEP) begin
        sweep_cnt  <= sweep_cnt + 1'b1;   // wraps to 0 on the final set
        starve_cnt <= '0;
      end else if (bus.inv_start || bus.fetch_gnt || !bus.fetch_req) begin
        starve_cnt <= '0;
      end else if (bus.fill_gnt && (starve_cnt < SC_W'(STARVE))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_icache_tag_ctl.sv
// Directed and constrained-random bench for icache_tag_ctl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_icache_tag_ctl;
  localparam int IDX_W  = 7;
  localparam int TAG_W  = 33;
  localparam int STARVE = 3;
  localparam int SETS   = 1 << IDX_W;

  logic rclk = 1'b0;
  logic reset_l;
  int   checks = 0;
  int   errors = 0;

  icache_tag_ctl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  icache_tag_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .STARVE(STARVE)) dut (
    .rclk    (rclk),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  always #5 rclk = ~rclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.fetch_req = 1'b0;
    bus.fetch_idx = '0;
    bus.fill_req  = 1'b0;
    bus.fill_idx  = '0;
    bus.fill_way  = 4'b0000;
    bus.fill_tag  = '0;
    bus.inv_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    clear_inputs();
    @(negedge rclk); @(negedge rclk);
    #1;
    checks++;
    if ({bus.inv_busy, bus.wrreq_x, bus.rdreq_x, bus.wrway_x, bus.index_x,
         bus.fetch_gnt, bus.fill_gnt, bus.rdvld_y} !== {1'b1, 1'b1, 1'b0, 4'hF, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b wr=%b rd=%b way=%h idx=%0d gnt=%b%b rdvld=%b, want busy=1 wr=1 rd=0 way=f idx=0 gnt=00 rdvld=0",
               bus.inv_busy, bus.wrreq_x, bus.rdreq_x, bus.wrway_x, bus.index_x,
               bus.fetch_gnt, bus.fill_gnt, bus.rdvld_y);
    end
    checks++;
    if (bus.wrtag_y !== '0) begin
      errors++;
      $display("FAIL reset_wrtag: got %h want 0", bus.wrtag_y);
    end
  endtask

  task automatic test_sweep();
    @(negedge rclk);
    reset_l = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      #1;
      checks++;
      if ({bus.index_x, bus.wrreq_x, bus.wrway_x, bus.rdreq_x, bus.inv_busy, bus.fetch_gnt, bus.fill_gnt}
          !== {7'(i), 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sweep_cycle_%0d: idx=%0d wr=%b way=%h rd=%b busy=%b, want idx=%0d wr=1 way=f rd=0 busy=1",
                 i, bus.index_x, bus.wrreq_x, bus.wrway_x, bus.rdreq_x, bus.inv_busy, i);
      end
      @(negedge rclk);
    end
    #1;
    checks++;
    if ({bus.inv_busy, bus.wrreq_x, bus.rdreq_x, bus.wrway_x} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL sweep_end: busy=%b wr=%b rd=%b way=%h, want all 0",
               bus.inv_busy, bus.wrreq_x, bus.rdreq_x, bus.wrway_x);
    end
  endtask

  task automatic test_fetch();
    @(negedge rclk);
    bus.fetch_req = 1'b1;
    bus.fetch_idx = 7'd5;
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.fill_gnt, bus.rdreq_x, bus.wrreq_x, bus.index_x} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'd5}) begin
      errors++;
      $display("FAIL fetch_grant: gnt=%b%b rd=%b wr=%b idx=%0d, want gnt=10 rd=1 wr=0 idx=5",
               bus.fetch_gnt, bus.fill_gnt, bus.rdreq_x, bus.wrreq_x, bus.index_x);
    end
    @(negedge rclk);
    bus.fetch_req = 1'b0;
    #1;
    checks++;
    if ({bus.rdvld_y, bus.rdreq_x} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_rdvld: rdvld=%b rd=%b, want rdvld=1 rd=0", bus.rdvld_y, bus.rdreq_x);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (bus.rdvld_y !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rdvld_drop: rdvld=%b want 0", bus.rdvld_y);
    end
  endtask

  task automatic test_starve();
    logic [TAG_W-1:0] tag_a = 33'h1_2345_6789;
    logic [TAG_W-1:0] tag_b = 33'h0_0F0F_0F0F;
    @(negedge rclk);
    bus.fetch_req = 1'b1;
    bus.fetch_idx = 7'd3;
    bus.fill_req  = 1'b1;
    bus.fill_idx  = 7'd9;
    bus.fill_way  = 4'b0100;
    bus.fill_tag  = tag_a;
    for (int k = 0; k < STARVE; k++) begin
      #1;
      checks++;
      if ({bus.fill_gnt, bus.fetch_gnt, bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.wrway_x}
          !== {1'b1, 1'b0, 1'b1, 1'b0, 7'd9, 4'b0100}) begin
        errors++;
        $display("FAIL starve_fill_%0d: gnt(fill,fetch)=%b%b wr=%b rd=%b idx=%0d way=%b, want 10 wr=1 rd=0 idx=9 way=0100",
                 k, bus.fill_gnt, bus.fetch_gnt, bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.wrway_x);
      end
      checks++;
      if (bus.wrtag_y !== ((k == 0) ? 33'h0 : tag_a)) begin
        errors++;
        $display("FAIL starve_wrtag_%0d: got %h want %h", k, bus.wrtag_y, (k == 0) ? 33'h0 : tag_a);
      end
      @(negedge rclk);
    end
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.fill_gnt, bus.rdreq_x, bus.wrreq_x, bus.index_x, bus.wrtag_y}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 7'd3, tag_a}) begin
      errors++;
      $display("FAIL starve_fetch_wins: gnt(fetch,fill)=%b%b rd=%b wr=%b idx=%0d tag=%h, want 10 rd=1 wr=0 idx=3 tag=%h",
               bus.fetch_gnt, bus.fill_gnt, bus.rdreq_x, bus.wrreq_x, bus.index_x, bus.wrtag_y, tag_a);
    end
    @(negedge rclk);
    #1;
    checks++;
    if ({bus.rdvld_y, bus.fill_gnt, bus.fetch_gnt} !== 3'b110) begin
      errors++;
      $display("FAIL starve_rearm: rdvld=%b fill_gnt=%b fetch_gnt=%b, want 1 1 0",
               bus.rdvld_y, bus.fill_gnt, bus.fetch_gnt);
    end
    @(negedge rclk);
    bus.fetch_req = 1'b0;
    bus.fill_req  = 1'b0;
    #1;
    checks++;
    if ({bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.wrtag_y} !== {1'b0, 1'b0, 7'd3, tag_a}) begin
      errors++;
      $display("FAIL idle_hold: wr=%b rd=%b idx=%0d tag=%h, want wr=0 rd=0 idx=3 tag=%h",
               bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.wrtag_y, tag_a);
    end
    @(negedge rclk);
    bus.fill_req = 1'b1;
    bus.fill_idx = 7'd127;
    bus.fill_way = 4'b1010;
    bus.fill_tag = tag_b;
    #1;
    checks++;
    if ({bus.fill_gnt, bus.wrreq_x, bus.index_x, bus.wrway_x} !== {1'b1, 1'b1, 7'd127, 4'b1010}) begin
      errors++;
      $display("FAIL multihot_fill: gnt=%b wr=%b idx=%0d way=%b, want 1 1 127 1010",
               bus.fill_gnt, bus.wrreq_x, bus.index_x, bus.wrway_x);
    end
    @(negedge rclk);
    bus.fill_req = 1'b0;
    #1;
    checks++;
    if (bus.wrtag_y !== tag_b) begin
      errors++;
      $display("FAIL multihot_wrtag: got %h want %h", bus.wrtag_y, tag_b);
    end
  endtask

  task automatic test_same_index();
    @(negedge rclk);
    bus.fetch_req = 1'b1;
    bus.fetch_idx = 7'd20;
    bus.fill_req  = 1'b1;
    bus.fill_idx  = 7'd20;
    bus.fill_way  = 4'b0001;
    bus.fill_tag  = 33'h1_AAAA_5555;
    #1;
    checks++;
    if ({bus.fill_gnt, bus.fetch_gnt, bus.index_x} !== {1'b1, 1'b0, 7'd20}) begin
      errors++;
      $display("FAIL same_idx_fill: fill=%b fetch=%b idx=%0d, want 1 0 20", bus.fill_gnt, bus.fetch_gnt, bus.index_x);
    end
    @(negedge rclk);
    bus.fill_req = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.rdreq_x, bus.index_x, bus.wrtag_y} !== {1'b1, 1'b1, 7'd20, 33'h1_AAAA_5555}) begin
      errors++;
      $display("FAIL same_idx_retry: fetch=%b rd=%b idx=%0d tag=%h, want 1 1 20 1aaaa5555",
               bus.fetch_gnt, bus.rdreq_x, bus.index_x, bus.wrtag_y);
    end
    @(negedge rclk);
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_inv();
    logic [TAG_W-1:0] tag_c = 33'h1_0000_00C3;
    @(negedge rclk);
    bus.fill_req  = 1'b1;
    bus.fill_idx  = 7'd2;
    bus.fill_way  = 4'b0001;
    bus.fill_tag  = tag_c;
    bus.inv_start = 1'b1;
    #1;
    checks++;
    if ({bus.fill_gnt, bus.wrreq_x, bus.wrway_x, bus.index_x, bus.inv_busy} !== {1'b1, 1'b1, 4'b0001, 7'd2, 1'b0}) begin
      errors++;
      $display("FAIL inv_fill_same_cycle: gnt=%b wr=%b way=%b idx=%0d busy=%b, want 1 1 0001 2 0",
               bus.fill_gnt, bus.wrreq_x, bus.wrway_x, bus.index_x, bus.inv_busy);
    end
    @(negedge rclk);
    bus.fetch_req = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      bus.inv_start = (i == 60);
      #1;
      checks++;
      if ({bus.index_x, bus.wrreq_x, bus.wrway_x, bus.rdreq_x, bus.inv_busy, bus.fetch_gnt, bus.fill_gnt}
          !== {7'(i), 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL inv_sweep_%0d: idx=%0d wr=%b way=%h rd=%b busy=%b gnt=%b%b, want idx=%0d wr=1 way=f rd=0 busy=1 gnt=00",
                 i, bus.index_x, bus.wrreq_x, bus.wrway_x, bus.rdreq_x, bus.inv_busy,
                 bus.fetch_gnt, bus.fill_gnt, i);
      end
      if (i < 2) begin
        checks++;
        if (bus.wrtag_y !== ((i == 0) ? tag_c : 33'h0)) begin
          errors++;
          $display("FAIL inv_wrtag_%0d: got %h want %h", i, bus.wrtag_y, (i == 0) ? tag_c : 33'h0);
        end
      end
      @(negedge rclk);
    end
    bus.inv_start = 1'b0;
    #1;
    checks++;
    if ({bus.inv_busy, bus.fill_gnt, bus.fetch_gnt} !== 3'b010) begin
      errors++;
      $display("FAIL inv_end: busy=%b fill=%b fetch=%b, want 0 1 0", bus.inv_busy, bus.fill_gnt, bus.fetch_gnt);
    end
    @(negedge rclk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge rclk);
    bus.inv_start = 1'b1;
    @(negedge rclk);
    bus.inv_start = 1'b0;
    for (int i = 0; i < 60; i++) @(negedge rclk);
    #1;
    checks++;
    if (bus.index_x !== 7'd60) begin
      errors++;
      $display("FAIL mid_reset_pre: idx=%0d want 60", bus.index_x);
    end
    #2;
    reset_l = 1'b0;
    #1;
    checks++;
    if ({bus.index_x, bus.inv_busy, bus.wrreq_x, bus.rdvld_y, bus.wrtag_y} !== {7'd0, 1'b1, 1'b1, 1'b0, 33'h0}) begin
      errors++;
      $display("FAIL mid_reset_async: idx=%0d busy=%b wr=%b rdvld=%b tag=%h, want 0 1 1 0 0",
               bus.index_x, bus.inv_busy, bus.wrreq_x, bus.rdvld_y, bus.wrtag_y);
    end
    @(negedge rclk); @(negedge rclk);
    reset_l = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      #1;
      checks++;
      if ({bus.index_x, bus.wrreq_x, bus.inv_busy} !== {7'(i), 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL mid_reset_sweep_%0d: idx=%0d wr=%b busy=%b, want idx=%0d wr=1 busy=1",
                 i, bus.index_x, bus.wrreq_x, bus.inv_busy, i);
      end
      @(negedge rclk);
    end
    #1;
    checks++;
    if (bus.inv_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_end: busy=%b want 0", bus.inv_busy);
    end
  endtask

  task automatic test_random();
    int  m_starve = 0;
    int  wait_cnt = 0;
    bit  prev_rd  = 1'b0;
    bit  prev_fetch_gnt = 1'b0;
    bit  prev_fill_gnt  = 1'b0;
    bit  exp_fill, exp_fetch;
    logic [IDX_W-1:0] exp_idx;
    @(negedge rclk);
    clear_inputs();
    #1;
    prev_rd = bus.rdreq_x;
    for (int c = 0; c < 3000; c++) begin
      @(negedge rclk);
      if (prev_fetch_gnt || !bus.fetch_req) begin
        bus.fetch_req = ($urandom_range(0, 99) < 60);
        bus.fetch_idx = IDX_W'($urandom);
      end
      if (prev_fill_gnt || !bus.fill_req) begin
        bus.fill_req = ($urandom_range(0, 99) < 80);
        bus.fill_idx = IDX_W'($urandom);
        bus.fill_way = 4'(1 << $urandom_range(0, 3));
        bus.fill_tag = {1'($urandom), $urandom};
      end
      #1;
      exp_fill  = bus.fill_req && (!bus.fetch_req || m_starve < STARVE);
      exp_fetch = !exp_fill && bus.fetch_req;
      exp_idx   = exp_fill ? bus.fill_idx : bus.fetch_idx;
      checks++;
      if ({bus.fill_gnt, bus.fetch_gnt, bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.rdvld_y}
          !== {exp_fill, exp_fetch, exp_fill, exp_fetch, exp_idx, prev_rd}) begin
        errors++;
        $display("FAIL random_arb_%0d: fill=%b fetch=%b wr=%b rd=%b idx=%0d rdvld=%b, want %b %b %b %b %0d %b",
                 c, bus.fill_gnt, bus.fetch_gnt, bus.wrreq_x, bus.rdreq_x, bus.index_x, bus.rdvld_y,
                 exp_fill, exp_fetch, exp_fill, exp_fetch, exp_idx, prev_rd);
      end
      if (bus.fetch_req && !bus.fetch_gnt) wait_cnt++;
      else                                 wait_cnt = 0;
      checks++;
      if (wait_cnt > STARVE) begin
        errors++;
        $display("FAIL random_starve_%0d: fetch waited %0d cycles, limit %0d", c, wait_cnt, STARVE);
      end
      if (exp_fetch || !bus.fetch_req)        m_starve = 0;
      else if (exp_fill && m_starve < STARVE) m_starve++;
      prev_rd        = exp_fetch;
      prev_fetch_gnt = bus.fetch_gnt;
      prev_fill_gnt  = bus.fill_gnt;
    end
    @(negedge rclk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_fetch();
    test_starve();
    test_same_index();
    test_inv();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
